// File: rtl/ws2812_bit_decoder_if.sv
// One-wire receive bundle: the line in, decoded words and strobes out.
// All outputs are single-cycle strobes with no ready: the consumer must capture data on the cycle valid is high.
interface ws2812_bit_decoder_if #(
  parameter int W = 24
);
  logic         din;
  logic [W-1:0] data;
  logic         valid;
  logic         frame_end;
  logic         err;

  modport master (output din, input data, valid, frame_end, err);
  modport slave  (input din, output data, valid, frame_end, err);
endinterface

// File: rtl/ws2812_bit_decoder.sv
// WS2812 pulse-width receiver: times each high pulse, classifies it as a bit,
// assembles MSB-first words and flags latch gaps, partial words and stuck-high lines.
module ws2812_bit_decoder #(
  parameter int W            = 24,
  parameter int THRESH       = 30,
  parameter int MIN_HIGH     = 5,
  parameter int RESET_CYCLES = 2500
) (
  input  logic                  clk,
  input  logic                  rst,
  ws2812_bit_decoder_if.slave   bus,
  output logic [1:0]            state_o
);

  localparam int CW = $clog2(RESET_CYCLES + 1);
  localparam int BW = $clog2(W + 1);
  localparam logic [CW-1:0] MIN_HIGH_C = CW'(MIN_HIGH);
  localparam logic [CW-1:0] THRESH_C   = CW'(THRESH);
  localparam logic [CW-1:0] RESET_C    = CW'(RESET_CYCLES);
  localparam logic [BW-1:0] LAST_BIT_C = BW'(W - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, WAIT_LOW} state_e;

  state_e        state_q, state_d;
  logic          s1_q, s2_q, s3_q;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] lcnt_q, lcnt_d;
  logic [BW-1:0] bitcnt_q, bitcnt_d;
  logic [W-1:0]  shift_q, shift_d;
  logic [W-1:0]  data_q, data_d;
  logic          valid_q, valid_d;
  logic          frame_end_q, frame_end_d;
  logic          err_q, err_d;

  logic          rise, fall, new_bit;
  logic [W-1:0]  word_next;

  assign rise      = s2_q & ~s3_q;
  assign fall      = ~s2_q & s3_q;
  assign new_bit   = (hcnt_q >= THRESH_C);
  assign word_next = {shift_q[W-2:0], new_bit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      state_q     <= IDLE;
      hcnt_q      <= '0;
      lcnt_q      <= '0;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_end_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      s1_q        <= bus.din;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      lcnt_q      <= lcnt_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_end_q <= frame_end_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    lcnt_d      = lcnt_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_end_d = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HIGH;
          hcnt_d  = CW'(1);
        end
      end
      HIGH: begin
        if (fall) begin
          // Pulses shorter than MIN_HIGH are line noise and leave the word untouched.
          if (hcnt_q >= MIN_HIGH_C) begin
            shift_d = word_next;
            if (bitcnt_q == LAST_BIT_C) begin
              data_d   = word_next;
              valid_d  = 1'b1;
              bitcnt_d = '0;
            end else begin
              bitcnt_d = bitcnt_q + BW'(1);
            end
          end
          state_d = LOW;
          lcnt_d  = CW'(1);
        end else if (hcnt_q == RESET_C) begin
          err_d    = 1'b1;
          bitcnt_d = '0;
          state_d  = WAIT_LOW;
        end else begin
          hcnt_d = hcnt_q + CW'(1);
        end
      end
      LOW: begin
        // A rise on the expiry cycle keeps the frame alive.
        if (rise) begin
          state_d = HIGH;
          hcnt_d  = CW'(1);
        end else if (lcnt_q == RESET_C) begin
          frame_end_d = 1'b1;
          err_d       = (bitcnt_q != '0);
          bitcnt_d    = '0;
          state_d     = IDLE;
        end else begin
          lcnt_d = lcnt_q + CW'(1);
        end
      end
      WAIT_LOW: begin
        if (fall) begin
          state_d = LOW;
          lcnt_d  = CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_end = frame_end_q;
  assign bus.err       = err_q;
  assign state_o       = state_q;

endmodule
